// File: rtl/ram_scan_reader_if.sv
// Bundle between the RAM read sequencer, its button debouncers, the RAM read
// port and the seven-segment display split logic.
interface ram_scan_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // Control pulses from the debouncers (single-cycle, level for step_mode)
  logic              start;
  logic              step_mode;
  logic              next;
  logic              abort;
  // RAM read port
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;
  // Display side
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              busy;
  logic              done;
  // Current sequencer state, for observation only
  logic [2:0]        dbg_state;

  // Handshake: disp_valid is a one-cycle valid with no ready. disp_addr and
  // disp_data change only on the edge that raises disp_valid and stay put
  // until the next pulse, so the display may sample them at any time; done
  // pulses once, on the same edge that drops busy.
  modport master (
    input  start, step_mode, next, abort, ram_dout,
    output ram_addr, ram_we, disp_addr, disp_data, disp_valid, busy, done,
           dbg_state
  );

  modport slave (
    output start, step_mode, next, abort, ram_dout,
    input  ram_addr, ram_we, disp_addr, disp_data, disp_valid, busy, done,
           dbg_state
  );
endinterface

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the display block RAM: walks every address, waits
// out the RAM read latency, and holds each word for the display either for a
// fixed dwell (free-run) or until the next button pulse (step mode).
module ram_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int DWELL  = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  ram_scan_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
  // WAIT covers RD_LAT-1 cycles; with RD_LAT=1 ISSUE skips WAIT entirely
  localparam logic [1:0]        LAT_LAST   = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  state_t            state;
  logic [1:0]        lat_cnt;
  logic [DW_W-1:0]   dwell_cnt;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              hold_advance;

  // Leave HOLD on a next pulse in step mode, or on dwell expiry in free-run
  always_comb begin
    hold_advance = 1'b0;
    if (state == S_HOLD) begin
      hold_advance = bus.step_mode ? bus.next : (dwell_cnt == DWELL_LAST);
    end
  end

  // Scan sequencer; abort from any busy state beats every other event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      dwell_cnt    <= '0;
      ram_addr_q   <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (bus.abort && (state != S_IDLE)) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state      <= S_ISSUE;
              ram_addr_q <= '0;
              busy_q     <= 1'b1;
            end
          end
          S_ISSUE: begin
            lat_cnt <= '0;
            state   <= (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
          end
          S_WAIT: begin
            if (lat_cnt == LAT_LAST) begin
              state <= S_CAPTURE;
            end else begin
              lat_cnt <= lat_cnt + 2'd1;
            end
          end
          S_CAPTURE: begin
            disp_data_q  <= bus.ram_dout;
            disp_addr_q  <= ram_addr_q;
            disp_valid_q <= 1'b1;
            dwell_cnt    <= '0;
            state        <= S_HOLD;
          end
          S_HOLD: begin
            // Step mode parks the dwell count so a return to free-run starts fresh
            if (bus.step_mode) begin
              dwell_cnt <= '0;
            end else if (!hold_advance) begin
              dwell_cnt <= dwell_cnt + DW_W'(1);
            end
            if (hold_advance) begin
              if (ram_addr_q == ADDR_LAST) begin
                state      <= S_IDLE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                ram_addr_q <= '0;
              end else begin
                ram_addr_q <= ram_addr_q + ADDR_W'(1);
                state      <= S_ISSUE;
              end
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = 1'b0;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.dbg_state  = state;

endmodule

// File: doc/ram_scan_reader.md
# ram_scan_reader

Read-side sequencer for the 256 x 16 single-port block RAM: on a debounced start pulse it walks the RAM address space, issues reads, waits out the RAM read latency, and holds each address/data pair for the seven-segment display driver. It runs either free (fixed dwell per word) or single-step (advance on a debounced button pulse). It sits between the button debouncers and the RAM port, and drives the display split logic when the write path is idle.

## Interface
- ADDR_W, 8, RAM address width; scan covers 0 .. 2^ADDR_W-1
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles (address sampled to douta valid); legal 1..4
- DWELL, 50_000_000, cycles each word is held in free-run mode (1 s at 50 MHz); legal >= 1

- clk  in  1  system clock (board oscillator); all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse from debouncer; begins a scan from address 0
- step_mode  in  1  1 = advance on `next`, 0 = advance after DWELL; sampled on every cycle
- next  in  1  single-cycle pulse from debouncer; advances in step mode
- abort  in  1  single-cycle pulse; ends the scan and returns to IDLE
- ram_dout  in  DATA_W  RAM read data (douta)
- ram_addr  out  ADDR_W  RAM read address, registered
- ram_we  out  1  tied 0; this block never writes
- disp_addr  out  ADDR_W  address of the word currently displayed
- disp_data  out  DATA_W  data of the word currently displayed
- disp_valid  out  1  one-cycle pulse when disp_addr/disp_data update
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last address is displayed and released

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, HOLD.
- IDLE: busy=0. `start` -> ISSUE with ram_addr=0.
- ISSUE (1 cycle): ram_addr stable; lat counter cleared -> WAIT.
- WAIT: counts RD_LAT-1 further cycles (zero cycles when RD_LAT=1) -> CAPTURE.
- CAPTURE (1 cycle): at its end, disp_data<=ram_dout, disp_addr<=ram_addr, disp_valid<=1 for the next cycle; dwell counter loaded -> HOLD.
- HOLD, free-run: dwell counter counts DWELL cycles including the disp_valid cycle. At expiry: if ram_addr == 2^ADDR_W-1 -> IDLE with done pulse; else ram_addr+1 -> ISSUE.
- HOLD, step mode: waits for `next`, then applies the same advance/finish rule. The dwell counter is ignored while step_mode=1. Switching step_mode to 0 mid-HOLD restarts the dwell count from 0.
- Address increment is modulo 2^ADDR_W. After done, ram_addr wraps to 0. disp_addr/disp_data keep the last word.
- `start` while busy: ignored.
- `next` outside HOLD, or with step_mode=0: ignored; it is not queued.
- `abort` in any busy state -> IDLE next cycle, no done pulse. disp_* hold their last values; a pending capture is dropped.
- Simultaneous `abort` and `next` in HOLD: abort wins.
- Simultaneous `start` and `abort` in IDLE: start wins.
- rst (any time, including mid-scan): state=IDLE, ram_addr=0, disp_addr=0, disp_data=0, disp_valid=0, busy=0, done=0, counters=0, ram_we=0. Takes effect immediately and asynchronously.

## Timing
- `start` sampled at edge E0. ram_addr=0 and busy=1 from E0.
- Data captured at edge E0+RD_LAT+1. disp_valid is high during the cycle after that edge, i.e. 2+RD_LAT cycles after E0.
- Free-run word period = 1 + RD_LAT + DWELL cycles. A full scan is 2^ADDR_W x that period.
- Step mode: `next` at edge En gives a new disp_valid 2+RD_LAT cycles after En.
- done asserts 1 cycle, coincident with the busy 1->0 transition.
- ram_addr changes only on the ISSUE entry edge, so it is stable for ≥ RD_LAT+1 cycles before capture.

## Test plan
- Reset mid-scan: assert rst during WAIT -> all outputs 0 within the same cycle and state IDLE; a later `start` resumes from address 0.
- Free-run timing (RD_LAT=1, DWELL=4, ADDR_W=3, RAM preloaded addr*16'h1111): start -> disp_valid pulses at 3, 9, 15, ... cycles after E0 with data 0000, 1111, 2222, ...; done pulses once after address 7; busy falls on the same cycle.
- RD_LAT=3 sweep -> first disp_valid 5 cycles after E0; captured data matches the model RAM with no off-by-one.
- Step mode: step_mode=1, `next` pulses at irregular gaps -> exactly one advance per pulse. Extra `next` during WAIT produces no skip. `start` while busy produces no restart.
- Abort in HOLD with simultaneous `next` -> IDLE next cycle, no done, disp_data unchanged, ram_addr not incremented.
- Wrap: ADDR_W=3 full scan, then second `start` -> ram_addr sequence 0..7, then 0..7 again, with identical data.
